// File: rtl/bloons_pkg.sv
// Shared bloon-game types and default sizes used by the leak arbiter and its bench.
package bloons_pkg;

  typedef enum logic {PLAY, GAME_OVER} game_state_e;

  localparam int NUM_BLOONS = 32;
  localparam int LIFE_W     = 8;
  localparam int DMG_W      = 4;

  typedef logic [DMG_W-1:0] dmg_t;

endpackage

// File: rtl/leak_arbiter_rr.sv
// Round-robin arbiter: first eligible request at or after the pointer wins, pointer moves past it.
module rr_arbiter #(
  parameter int N     = 32,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             Clk,
  input  logic             clr,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     elig;
  logic [IDX_W:0]   pos;

  assign elig = req & ~mask;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int k = 0; k < N; k++) begin
      // Rotated index, wrapped modulo N without a divider.
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!grant_valid && elig[pos]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[IDX_W-1:0];
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid)
      ptr_d = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (clr) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/leak_arbiter.sv
// Serializes bloon leaks into the shared life pool; one grant per cycle, PLAY/GAME_OVER FSM.
// Optional +1 life input enabled by defining LEAK_ARBITER_EXTRA_LIFE_EN.
module leak_arbiter
  import bloons_pkg::*;
#(
  parameter int NUM_BLOONS  = bloons_pkg::NUM_BLOONS,
  parameter int LIFE_W      = bloons_pkg::LIFE_W,
  parameter int DMG_W       = bloons_pkg::DMG_W,
  parameter int START_LIVES = 100,
  parameter int MAX_LIVES   = 255
) (
  input  logic                             Clk,
  input  logic                             reset,
  input  logic                             new_game,
  input  logic [NUM_BLOONS-1:0]            leak_req,
  input  logic [NUM_BLOONS-1:0][DMG_W-1:0] leak_dmg,
`ifdef LEAK_ARBITER_EXTRA_LIFE_EN
  input  logic                             add_life,
`endif
  output logic [NUM_BLOONS-1:0]            leak_ack,
  output logic [LIFE_W-1:0]                lives,
  output logic                             game_over
);

  localparam int IDX_W = (NUM_BLOONS > 1) ? $clog2(NUM_BLOONS) : 1;

  game_state_e                state_q, state_d;
  logic [LIFE_W-1:0]          lives_q, lives_d;
  logic [NUM_BLOONS-1:0]      ack_q, ack_d;

  logic [NUM_BLOONS-1:0]      grant;
  logic [IDX_W-1:0]           grant_idx;
  logic                       grant_valid;
  logic [DMG_W-1:0]           win_dmg;
  logic [DMG_W-1:0]           eff_dmg;
  logic signed [LIFE_W+1:0]   lives_calc;

  function automatic logic [LIFE_W-1:0] sat_lives(input logic signed [LIFE_W+1:0] v);
    if (v <= 0) return '0;
`ifdef LEAK_ARBITER_EXTRA_LIFE_EN
    if (v > MAX_LIVES) return LIFE_W'(MAX_LIVES);
`endif
    return v[LIFE_W-1:0];
  endfunction

  // Masking with the live ack stops a slot being charged twice for one leak.
  rr_arbiter #(.N(NUM_BLOONS), .IDX_W(IDX_W)) u_rr (
    .Clk        (Clk),
    .clr        (reset | new_game),
    .req        (leak_req),
    .mask       (ack_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  assign win_dmg = leak_dmg[grant_idx];
  assign eff_dmg = !grant_valid ? '0 : (win_dmg == '0) ? DMG_W'(1) : win_dmg;

  always_comb begin
    lives_calc = signed'({2'b00, lives_q}) - signed'((LIFE_W+2)'(eff_dmg));
`ifdef LEAK_ARBITER_EXTRA_LIFE_EN
    lives_calc = lives_calc + signed'((LIFE_W+2)'(add_life));
`endif
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    ack_d   = '0;
    if (new_game) begin
      state_d = PLAY;
      lives_d = LIFE_W'(START_LIVES);
    end else begin
      ack_d = grant;
      case (state_q)
        PLAY: begin
          lives_d = sat_lives(lives_calc);
          if (lives_d == '0) state_d = GAME_OVER;
        end
        GAME_OVER: lives_d = '0;
        default:   state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= PLAY;
      lives_q <= LIFE_W'(START_LIVES);
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      ack_q   <= ack_d;
    end
  end

  assign leak_ack  = ack_q;
  assign lives     = lives_q;
  assign game_over = (state_q == GAME_OVER);

endmodule

// File: doc/leak_arbiter.md
# leak_arbiter

Shares the player's life pool among all bloon slots. Every slot whose bloon reaches the track exit raises a leak request carrying a damage value. The block grants one request per cycle in round-robin order, subtracts that damage from `lives` with saturation at zero, and runs the PLAY/GAME_OVER state machine. It sits between the bloon slot array and the HUD/game-control logic, and serializes the simultaneous leaks that the slots produce.

## Interface
- `NUM_BLOONS`, 32, number of requesting bloon slots
- `LIFE_W`, 8, width of `lives`
- `DMG_W`, 4, width of per-slot damage
- `START_LIVES`, 100, value loaded on reset and `new_game`
- `MAX_LIVES`, 255, saturation ceiling; used only with `EXTRA_LIFE_EN`

- `Clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `new_game`  in  1  pulse; reload lives, return to PLAY
- `leak_req`  in  [NUM_BLOONS]  level; slot i requests a life deduction
- `leak_dmg`  in  [NUM_BLOONS][DMG_W]  damage for slot i; valid while `leak_req[i]` is high
- `add_life`  in  1  pulse; +1 life (present only with `EXTRA_LIFE_EN`)
- `leak_ack`  out  [NUM_BLOONS]  one-hot registered pulse; slot's leak consumed
- `lives`  out  [LIFE_W]  current lives
- `game_over`  out  1  high in GAME_OVER

## Operation
- **Reset values:** `lives` = START_LIVES; `game_over` = 0; `leak_ack` = 0; state = PLAY; RR pointer = 0.
- **Eligible slot:** `leak_req[i]` high and `leak_ack[i]` low. This masks out the slot acked in the current cycle, which prevents double deduction.
- **Arbitration:**
  - Search starts at the pointer and wraps modulo NUM_BLOONS.
  - The first eligible slot wins.
  - After a grant, pointer = winner+1; index NUM_BLOONS-1 wraps to 0.
  - Pointer is unchanged when there is no grant.
- **Damage:** effective damage = `leak_dmg` of the winner, with 0 treated as 1.
- **PLAY:** lives_next = lives − dmg, computed in LIFE_W+1 bits and clamped at 0. If lives_next == 0, go to GAME_OVER.
- **GAME_OVER:**
  - `lives` is held at 0 and `game_over` = 1.
  - Requests are still granted and acked, one per cycle and round-robin, so slots can despawn. No deduction is made.
- **Handshake:**
  - A requester holds `leak_req` and `leak_dmg` stable until it samples `leak_ack`.
  - It must deassert `leak_req` on that same edge.
  - A request still high one cycle after its ack is treated as a new leak.
- **`new_game`:**
  - Allowed in any state.
  - lives = START_LIVES, state = PLAY, pointer = 0, `leak_ack` = 0.
  - Any grant in the same cycle is dropped, and that requester is not acked.
- **`reset` mid-operation:** same effect as `new_game`, plus all outputs return to their reset values. A reset that coincides with a request discards the request. `reset` has priority over `new_game`.

## Timing
- Request high before edge k and winning → `lives` updated and `leak_ack[i]` high in the cycle after edge k. Latency 1 cycle.
- Throughput: one leak per cycle.
- Worst-case wait with all slots requesting: NUM_BLOONS−1 cycles.
- `game_over` rises on the same edge that `lives` reaches 0.
- Leak and `add_life` in the same cycle: both are applied in a single update.

## Configuration
- `LEAK_ARBITER_EXTRA_LIFE_EN` defined:
  - `add_life` port exists.
  - In PLAY, lives_next = clamp(lives + add_life − dmg, 0, MAX_LIVES).
  - lives_next == 0 → GAME_OVER, even if `add_life` was high.
  - `add_life` is ignored in GAME_OVER.
- Undefined: the port is absent and only deductions occur.

## Structure
- Shared package `bloons_pkg` holds:
  - `game_state_e` {PLAY, GAME_OVER}
  - `LIFE_W`, `DMG_W`, `NUM_BLOONS` constants
  - `dmg_t` typedef
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: `req`, `mask`.
  - Outputs: one-hot `grant`, `grant_idx`, `grant_valid`.
  - Holds the pointer register; `clr` input serves reset and `new_game`.
- Top level: damage mux, saturating subtract, FSM, ack register.

## Test plan
- **Single leak:** reset, `leak_req[5]`=1 with dmg 3 → next cycle `leak_ack[5]`=1 and `lives`=97. Requester drops the request → no further change.
- **Round-robin:** slots 0, 3 and 31 request together with dmg 1 → acks in order 0, 3, 31 on consecutive cycles; `lives` goes 99, 98, 97; pointer ends at 0.
- **Underflow clamp:** `lives`=2, slot 7 leaks with dmg 9 → `lives`=0, `game_over`=1; a later leak on slot 8 is acked with `lives` staying 0.
- **Zero damage and held request:** dmg 0 → −1 life. Request held two cycles past its ack → second deduction, total −2.
- **Restart:** during GAME_OVER with requests pending, pulse `new_game` → `lives`=100, PLAY, no ack that cycle. Assert `reset` mid-burst → all outputs return to reset values.
- **Extra life (`LEAK_ARBITER_EXTRA_LIFE_EN`):**
  - `lives`=255 plus `add_life` → stays 255.
  - `lives`=1 with `add_life` and a dmg-1 leak together → `lives`=1, still PLAY.
  - `lives`=1 with `add_life` and a dmg-2 leak → 0, GAME_OVER.
